alu_host_requester: RTL and testbench
=====================================

Name: alu_host_requester

Overview:
- Host-side counterpart of interface_circuit: the initiator end of the UART ALU byte protocol.
- Accepts one ALU request (operand A, opcode, operand B) from a local client.
- Serialises the request as three bytes through a UART transmitter: A first, then opcode, then B.
- Waits for the single result byte from a UART receiver, then presents it to the client with a one-cycle valid pulse.

Parameters:
- CANT_DATOS_ENTRADA_ALU, 8, width of operands A and B.
- CANT_BITS_OPCODE_ALU, 8, width of the opcode.
- CANT_DATOS_SALIDA_ALU, 8, width of the result.
- WIDTH_WORD, 8, UART frame data width. All three widths above must equal WIDTH_WORD.
- TIMEOUT_CYCLES, 1000000, wait limit per handshake. Used only when HOST_TIMEOUT_EN is defined.

Ports:
- i_clock  in  1  system clock. The only clock in the block.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  request strobe. Sampled only in IDLE.
- i_dato_A  in  CANT_DATOS_ENTRADA_ALU  operand A. Captured when i_start is accepted.
- i_dato_B  in  CANT_DATOS_ENTRADA_ALU  operand B. Captured when i_start is accepted.
- i_opcode  in  CANT_BITS_OPCODE_ALU  opcode. Captured when i_start is accepted.
- i_tx_done  in  1  UART TX frame complete. Level; may stay high for many cycles.
- i_data_rx  in  WIDTH_WORD  UART RX received byte.
- i_rx_done  in  1  UART RX byte valid. Level; may stay high for many cycles.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_data_tx.
- o_data_tx  out  WIDTH_WORD  byte to transmit.
- o_resultado  out  CANT_DATOS_SALIDA_ALU  last received result.
- o_valid  out  1  one-cycle pulse: o_resultado updated.
- o_busy  out  1  high from request acceptance until return to IDLE.
- o_error  out  1  one-cycle pulse on timeout. Constant 0 without HOST_TIMEOUT_EN.

Behaviour:
- Reset (i_reset low, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0; the operand capture registers are 0.
  - Edge-detector history registers are set to 1, so a done line already high at reset release produces no edge.
- Done inputs are consumed as rising edges only. Edge = input & ~previous, with previous registered every cycle. This handles level-held done signals.
- States:
  - IDLE → SEND_A when i_start=1. Operands and opcode are latched on the same edge; o_busy goes high.
  - SEND_A: o_tx_start=1 for exactly one cycle, o_data_tx=A. Next state WAIT_A.
  - WAIT_A: o_data_tx held at A. On tx_done edge → SEND_OP.
  - SEND_OP / WAIT_OP: same pattern with the opcode byte. On tx_done edge → SEND_B.
  - SEND_B / WAIT_B: same pattern with B. On tx_done edge → WAIT_RES.
  - WAIT_RES: on rx_done edge, o_resultado <= i_data_rx and o_valid=1 on the next cycle. → IDLE.
- o_busy falls in the same cycle o_valid pulses.
- Latency:
  - i_start accepted at edge N gives the o_tx_start pulse in cycle N+1.
  - A tx_done edge detected in cycle M gives the next o_tx_start in cycle M+1.
- o_data_tx holds its last value in IDLE and never changes while in a WAIT state.
- Boundary conditions:
  - i_start while busy: ignored. The captured operands are not disturbed.
  - rx_done edge outside WAIT_RES: ignored (stale or unsolicited byte). o_resultado is unchanged.
  - tx_done edge outside the WAIT_A, WAIT_OP and WAIT_B states: ignored.
  - tx_done edge and rx_done edge in the same cycle: only the edge relevant to the current state acts.
  - Reset mid-transaction: immediate return to IDLE. The partially sent request is abandoned; no o_valid.
  - A request may be accepted in the cycle after o_valid.

Optional Feature:
- Macro: HOST_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to each WAIT state and increments every cycle spent there.
  - When the counter reaches TIMEOUT_CYCLES-1 without the expected edge: o_error pulses for one cycle, o_busy drops, FSM → IDLE.
  - o_resultado is unchanged and o_valid is not asserted.
- When undefined: no counter is synthesised, o_error is constant 0, and the WAIT states wait indefinitely.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, SEND_A, WAIT_A, SEND_OP, WAIT_OP, SEND_B, WAIT_B, WAIT_RES);
  - the width constants shared with interface_circuit (CANT_DATOS_ENTRADA_ALU, CANT_BITS_OPCODE_ALU, CANT_DATOS_SALIDA_ALU, WIDTH_WORD).
- One sub-module: rising_edge_detector (1-bit, history reset to 1), instantiated for i_tx_done and for i_rx_done.

Test Plan:
1. Nominal transaction:
   - Stimulus: A=2, opcode=3, B=1, i_start pulse. Each i_tx_done held high for 300 cycles, 200 cycles after each o_tx_start. i_data_rx=3 with i_rx_done held high for 300 cycles.
   - Required: o_data_tx sequence 2, 3, 1; exactly three o_tx_start pulses; o_valid once; o_resultado=3.
2. Level-held done:
   - Stimulus: i_tx_done stays high 1500 cycles across the SEND_OP entry.
   - Required: no extra o_tx_start; the opcode is not sent until a new rising edge.
3. Protocol violations:
   - Stimulus: i_start re-pulsed with A=9 during WAIT_OP; an unsolicited rx_done with byte 4 while in IDLE.
   - Required: the transmitted B is still 1; o_resultado stays 3; no o_valid.
4. Reset mid-operation:
   - Stimulus: i_reset low for 2 cycles during WAIT_B.
   - Required: all outputs 0 immediately. A new request A=5, opcode=0, B=7 then completes normally.
5. Timeout (HOST_TIMEOUT_EN defined, TIMEOUT_CYCLES=50):
   - Stimulus: no i_rx_done after B is sent.
   - Required: o_error pulses 50 cycles after WAIT_RES entry; o_busy drops; o_valid is never asserted.
6. Timeout compiled out:
   - Stimulus: same as scenario 5.
   - Required: o_busy stays high for 10000 cycles and o_error stays 0.

Source files
------------

// File: rtl/alu_host_requester_pkg.sv
// ============================================================================
//  Module   : alu_host_requester_pkg
//  Purpose  : Shared constants for the host-side UART ALU requester: the
//             widths shared with interface_circuit and the FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_host_requester_pkg;

  // Widths shared with the target-side interface_circuit.
  localparam int CANT_DATOS_ENTRADA_ALU = 8;
  localparam int CANT_BITS_OPCODE_ALU   = 8;
  localparam int CANT_DATOS_SALIDA_ALU  = 8;
  localparam int WIDTH_WORD             = 8;

  // Requester FSM encoding.
  localparam int         STATE_W  = 3;
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND_A   = 3'd1;
  localparam logic [2:0] WAIT_A   = 3'd2;
  localparam logic [2:0] SEND_OP  = 3'd3;
  localparam logic [2:0] WAIT_OP  = 3'd4;
  localparam logic [2:0] SEND_B   = 3'd5;
  localparam logic [2:0] WAIT_B   = 3'd6;
  localparam logic [2:0] WAIT_RES = 3'd7;

endpackage

`default_nettype wire

// File: rtl/alu_host_requester_rising_edge_detector.sv
// ============================================================================
//  Module   : rising_edge_detector
//  Purpose  : 1-bit rising-edge detector for level-held UART done lines.
//             History resets to 1 so a line already high at reset release
//             is not reported as an edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rising_edge_detector (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_edge
);
  import alu_host_requester_pkg::*;

  logic level_prev;

  // Remember last cycle's level of the monitored line.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      level_prev <= 1'b1;
    end else begin
      level_prev <= i_level;
    end
  end

  assign o_edge = i_level & ~level_prev;

endmodule

`default_nettype wire

// File: rtl/alu_host_requester.sv
// ============================================================================
//  Module   : alu_host_requester
//  Purpose  : Initiator end of the UART ALU byte protocol. Latches one request,
//             sends A, opcode, B through a UART TX, waits for the result byte
//             from a UART RX and returns it with a one-cycle valid pulse.
//  Options  : HOST_TIMEOUT_EN - per-handshake timeout of TIMEOUT_CYCLES cycles
//             with a one-cycle o_error pulse; without it o_error is 0 and the
//             WAIT states wait indefinitely.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_host_requester #(
  parameter int CANT_DATOS_ENTRADA_ALU = alu_host_requester_pkg::CANT_DATOS_ENTRADA_ALU,
  parameter int CANT_BITS_OPCODE_ALU   = alu_host_requester_pkg::CANT_BITS_OPCODE_ALU,
  parameter int CANT_DATOS_SALIDA_ALU  = alu_host_requester_pkg::CANT_DATOS_SALIDA_ALU,
  parameter int WIDTH_WORD             = alu_host_requester_pkg::WIDTH_WORD,
  parameter int TIMEOUT_CYCLES         = 1000000
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic [CANT_DATOS_ENTRADA_ALU-1:0] i_dato_A,
  input  logic [CANT_DATOS_ENTRADA_ALU-1:0] i_dato_B,
  input  logic [CANT_BITS_OPCODE_ALU-1:0]   i_opcode,
  input  logic                              i_tx_done,
  input  logic [WIDTH_WORD-1:0]             i_data_rx,
  input  logic                              i_rx_done,
  output logic                              o_tx_start,
  output logic [WIDTH_WORD-1:0]             o_data_tx,
  output logic [CANT_DATOS_SALIDA_ALU-1:0]  o_resultado,
  output logic                              o_valid,
  output logic                              o_busy,
  output logic                              o_error
);
  import alu_host_requester_pkg::*;

  // Every field travels as exactly one UART frame.
  if ((CANT_DATOS_ENTRADA_ALU != WIDTH_WORD) || (CANT_BITS_OPCODE_ALU != WIDTH_WORD) ||
      (CANT_DATOS_SALIDA_ALU != WIDTH_WORD)) begin : g_width_check
    $error("alu_host_requester: ALU field widths must equal WIDTH_WORD");
  end

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("alu_host_requester: TIMEOUT_CYCLES must be at least 2");
  end

  logic [STATE_W-1:0]              state;
  logic [CANT_BITS_OPCODE_ALU-1:0] op_q;
  logic [CANT_DATOS_ENTRADA_ALU-1:0] b_q;
  logic                            tx_start;
  logic [WIDTH_WORD-1:0]           data_tx;
  logic [CANT_DATOS_SALIDA_ALU-1:0] resultado;
  logic                            valid;
  logic                            busy;
  logic                            tx_edge;
  logic                            rx_edge;
  logic                            timeout_hit;

  rising_edge_detector u_tx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (i_tx_done),
    .o_edge  (tx_edge)
  );

  rising_edge_detector u_rx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (i_rx_done),
    .o_edge  (rx_edge)
  );

`ifdef HOST_TIMEOUT_EN
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             advance;
  logic             error;

  assign in_wait = (state == WAIT_A) || (state == WAIT_OP) ||
                   (state == WAIT_B) || (state == WAIT_RES);
  // The edge the current WAIT state is waiting for.
  assign advance = (state == WAIT_RES) ? rx_edge : (in_wait & tx_edge);
  assign timeout_hit = in_wait && !advance && (wait_cnt == CNT_LAST);

  // Cycles spent in the current WAIT state; zero on the first cycle of each.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wait_cnt <= '0;
    end else if (!in_wait || advance || timeout_hit) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // One-cycle error pulse following an expired wait.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      error <= 1'b0;
    end else begin
      error <= timeout_hit;
    end
  end

  assign o_error = error;
`else
  assign timeout_hit = 1'b0;
  assign o_error     = 1'b0;
`endif

  // Request sequencer. Operand A is not kept separately: it goes straight
  // into the TX byte register on acceptance and is held there during WAIT_A.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      op_q      <= '0;
      b_q       <= '0;
      tx_start  <= 1'b0;
      data_tx   <= '0;
      resultado <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            op_q     <= i_opcode;
            b_q      <= i_dato_B;
            data_tx  <= i_dato_A;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND_A;
          end
        end
        SEND_A:  state <= WAIT_A;
        WAIT_A: begin
          if (tx_edge) begin
            data_tx  <= op_q;
            tx_start <= 1'b1;
            state    <= SEND_OP;
          end else if (timeout_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SEND_OP: state <= WAIT_OP;
        WAIT_OP: begin
          if (tx_edge) begin
            data_tx  <= b_q;
            tx_start <= 1'b1;
            state    <= SEND_B;
          end else if (timeout_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SEND_B:  state <= WAIT_B;
        WAIT_B: begin
          if (tx_edge) begin
            state <= WAIT_RES;
          end else if (timeout_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT_RES: begin
          if (rx_edge) begin
            resultado <= i_data_rx;
            valid     <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (timeout_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_start  = tx_start;
  assign o_data_tx   = data_tx;
  assign o_resultado = resultado;
  assign o_valid     = valid;
  assign o_busy      = busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_host_requester.sv
// ============================================================================
//  Module   : tb_alu_host_requester
//  Purpose  : Self-checking bench for alu_host_requester: directed protocol
//             scenarios plus randomized transactions against a
//             transaction-level model (expected byte order and result).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_host_requester;

  localparam int TO    = 50;
  localparam int LIMIT = 5000;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] dato_a  = '0;
  logic [7:0] dato_b  = '0;
  logic [7:0] opcode  = '0;
  logic       tx_done = 1'b0;
  logic [7:0] data_rx = '0;
  logic       rx_done = 1'b0;

  logic       tx_start;
  logic [7:0] data_tx;
  logic [7:0] resultado;
  logic       valid;
  logic       busy;
  logic       error;

  always #5 clk = ~clk;

  alu_host_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_start     (start),
    .i_dato_A    (dato_a),
    .i_dato_B    (dato_b),
    .i_opcode    (opcode),
    .i_tx_done   (tx_done),
    .i_data_rx   (data_rx),
    .i_rx_done   (rx_done),
    .o_tx_start  (tx_start),
    .o_data_tx   (data_tx),
    .o_resultado (resultado),
    .o_valid     (valid),
    .o_busy      (busy),
    .o_error     (error)
  );

  int         n_checks    = 0;
  int         n_errors    = 0;
  int         valid_count = 0;
  logic [7:0] sent[$];
  logic [7:0] prev_dtx    = '0;
  logic       prev_start  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction monitor: logs transmitted bytes and result pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dtx   = data_tx;
      prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        sent.push_back(data_tx);
        check("tx_start_single_cycle", {31'd0, prev_start}, 32'd0);
      end
      if (data_tx !== prev_dtx) check("data_tx_changes_only_with_start", {31'd0, tx_start}, 32'd1);
      if (valid) begin
        valid_count++;
        check("busy_low_with_valid", {31'd0, busy}, 32'd0);
      end
`ifndef HOST_TIMEOUT_EN
      if (error !== 1'b0) check("error_const_zero", {31'd0, error}, 32'd0);
`endif
      prev_dtx   = data_tx;
      prev_start = tx_start;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sent(input int target, input string tag);
    int n = 0;
    while (sent.size() < target && n < LIMIT) begin
      tick(1);
      n++;
    end
    if (sent.size() < target) check(tag, sent.size(), target);
  endtask

  // Full request/response with the UART side modelled by fixed delay/hold.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b,
                         input logic [7:0] res, input int d, input int h, input bit disturb);
    int         base;
    int         vbase;
    logic [7:0] exp_bytes [3];
    exp_bytes = '{a, op, b};
    base  = sent.size();
    vbase = valid_count;
    dato_a = a; opcode = op; dato_b = b; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start_to_tx_start_latency", {31'd0, tx_start}, 32'd1);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_sent(base + i + 1, "wait_tx_start");
      if (disturb && i == 1) begin
        dato_a = 8'd9; dato_b = 8'd9; opcode = 8'd9; start = 1'b1;
        tick(1);
        start = 1'b0;
        data_rx = 8'd4; rx_done = 1'b1;
        tick(2);
        rx_done = 1'b0;
      end
      tick(d);
      tx_done = 1'b1;
      if (disturb && i == 2) begin
        data_rx = 8'd4; rx_done = 1'b1;
      end
      tick(1);
      if (i < 2) check("tx_done_to_next_start_latency", {31'd0, tx_start}, 32'd1);
      else       check("no_start_after_last_byte", {31'd0, tx_start}, 32'd0);
      if (h > 1) tick(h - 1);
      tx_done = 1'b0; rx_done = 1'b0;
      tick(1);
      check("pulses_after_handshake", sent.size(), base + ((i < 2) ? i + 2 : 3));
    end
    check("busy_in_wait_res", {31'd0, busy}, 32'd1);
    check("no_valid_before_result", valid_count, vbase);
    tick(d);
    data_rx = res; rx_done = 1'b1;
    tick(1);
    check("valid_pulse", {31'd0, valid}, 32'd1);
    check("result_value", {24'd0, resultado}, {24'd0, res});
    check("busy_drop_with_valid", {31'd0, busy}, 32'd0);
    tick(1);
    check("valid_one_cycle", {31'd0, valid}, 32'd0);
    if (h > 2) tick(h - 2);
    rx_done = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) check("tx_byte_order", {24'd0, sent[base + i]}, {24'd0, exp_bytes[i]});
    check("valid_count", valid_count, vbase + 1);
    check("result_held", {24'd0, resultado}, {24'd0, res});
  endtask

  // Start a request and complete n TX handshakes, leaving the DUT mid-request.
  task automatic send_bytes(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b, input int n);
    int base = sent.size();
    dato_a = a; opcode = op; dato_b = b; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_sent(base + i + 1, "wait_tx_start");
      tick(2);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vb;
    logic [7:0] ra, rop, rb;

    // Reset state.
    tick(3);
    check("reset_tx_start", {31'd0, tx_start}, 32'd0);
    check("reset_data_tx", {24'd0, data_tx}, 32'd0);
    check("reset_resultado", {24'd0, resultado}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Nominal transaction with long UART-like delays.
    run_txn(8'd2, 8'd3, 8'd1, 8'd3, 200, 300, 1'b0);

    // Level-held done lines spanning SEND state entries.
    run_txn(8'd17, 8'd6, 8'd40, 8'd57, 5, 1500, 1'b0);

    // Protocol violations inside a transaction, then an unsolicited byte.
    run_txn(8'd2, 8'd3, 8'd1, 8'd3, 10, 10, 1'b1);
    vb = valid_count;
    data_rx = 8'd4; rx_done = 1'b1;
    tick(5);
    rx_done = 1'b0;
    tick(2);
    check("unsolicited_rx_result_kept", {24'd0, resultado}, 32'd3);
    check("unsolicited_rx_no_valid", valid_count, vb);
    check("unsolicited_rx_not_busy", {31'd0, busy}, 32'd0);

    // Reset during WAIT_B, then a fresh request.
    vb = valid_count;
    send_bytes(8'd6, 8'd1, 8'd8, 2);
    tick(3);
    rst_n = 1'b0;
    #1;
    check("midreset_tx_start", {31'd0, tx_start}, 32'd0);
    check("midreset_data_tx", {24'd0, data_tx}, 32'd0);
    check("midreset_resultado", {24'd0, resultado}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("after_reset_idle", {31'd0, busy}, 32'd0);
    check("abandoned_no_valid", valid_count, vb);
    run_txn(8'd5, 8'd0, 8'd7, 8'd12, 3, 4, 1'b0);

    // Missing result byte.
    vb = valid_count;
    send_bytes(8'd11, 8'd2, 8'd3, 3);
`ifdef HOST_TIMEOUT_EN
    tick(TO - 1);
    check("no_early_timeout", {31'd0, error}, 32'd0);
    check("busy_before_timeout", {31'd0, busy}, 32'd1);
    tick(1);
    check("timeout_error_pulse", {31'd0, error}, 32'd1);
    check("timeout_busy_drop", {31'd0, busy}, 32'd0);
    tick(1);
    check("timeout_error_one_cycle", {31'd0, error}, 32'd0);
    check("timeout_no_valid", valid_count, vb);
`else
    for (int k = 0; k < 10; k++) begin
      tick(1000);
      check("busy_held_without_timeout", {31'd0, busy}, 32'd1);
    end
    check("no_valid_while_waiting", valid_count, vb);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
`endif

    // Randomized transactions; the model result is A+B as the fake ALU reply.
    for (int k = 0; k < 8; k++) begin
      ra  = 8'($urandom);
      rop = 8'($urandom);
      rb  = 8'($urandom);
      run_txn(ra, rop, rb, 8'(ra + rb), int'($urandom_range(1, 20)), int'($urandom_range(1, 30)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
